// File: rtl/ascon_permutation_ctrl_pkg.sv
// Shared types, round-constant table and start-index helper for the Ascon permutation controller.
package ascon_permutation_ctrl_pkg;

   localparam int MAX_ROUNDS = 12;
   localparam int RND_CNT_W  = 4;
   localparam logic [RND_CNT_W-1:0] LAST_IDX = 4'd11;

   // Word 0 is x0 (leftmost in a {x0,x1,x2,x3,x4} concatenation).
   typedef logic [0:4][63:0] type_state;

   typedef enum logic [1:0] {
      RND_12 = 2'd0,
      RND_8  = 2'd1,
      RND_6  = 2'd2
   } rnd_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

   function automatic logic [7:0] round_const(input logic [RND_CNT_W-1:0] r);
      case (r)
         4'd0:    return 8'hF0;
         4'd1:    return 8'hE1;
         4'd2:    return 8'hD2;
         4'd3:    return 8'hC3;
         4'd4:    return 8'hB4;
         4'd5:    return 8'hA5;
         4'd6:    return 8'h96;
         4'd7:    return 8'h87;
         4'd8:    return 8'h78;
         4'd9:    return 8'h69;
         4'd10:   return 8'h5A;
         4'd11:   return 8'h4B;
         default: return 8'h00;
      endcase
   endfunction

   // First schedule index: shorter permutations use the tail of the 12-round schedule.
   function automatic logic [RND_CNT_W-1:0] start_index(input logic [1:0] sel);
      case (sel)
         RND_8:   return 4'd4;
         RND_6:   return 4'd6;
         default: return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ascon_permutation_ctrl_if.sv
// Start/done handshake and state bus between the mode FSM (master) and the permutation controller (slave).
interface ascon_permutation_ctrl_if;
   import ascon_permutation_ctrl_pkg::*;

   logic                 start_i;
   logic [1:0]           rounds_sel_i;
   type_state            state_i;
   logic                 ready_o;
   logic                 done_o;
   type_state            state_o;
   logic [RND_CNT_W-1:0] round_o;

   modport master (
      output start_i, rounds_sel_i, state_i,
      input  ready_o, done_o, state_o, round_o
   );

   modport slave (
      input  start_i, rounds_sel_i, state_i,
      output ready_o, done_o, state_o, round_o
   );

endinterface

// File: rtl/ascon_permutation_ctrl_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion layer.
module ascon_permutation_ctrl_round
   import ascon_permutation_ctrl_pkg::*;
(
   input  type_state            state_i,
   input  logic [RND_CNT_W-1:0] round_i,
   output type_state            state_o
);

   function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Bitsliced S-box applied to all 64 columns at once.
   function automatic type_state sbox_layer(input type_state s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[0] ^ s[4];
      x1 = s[1];
      x2 = s[2] ^ s[1];
      x3 = s[3];
      x4 = s[4] ^ s[3];
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic type_state linear_layer(input type_state s);
      type_state o;
      o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
      o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
      o[2] = s[2] ^ rotr(s[2],  1) ^ rotr(s[2],  6);
      o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
      o[4] = s[4] ^ rotr(s[4],  7) ^ rotr(s[4], 41);
      return o;
   endfunction

   type_state added_s;

   always_comb begin
      added_s       = state_i;
      added_s[2][7:0] = state_i[2][7:0] ^ round_const(round_i);
   end

   assign state_o = linear_layer(sbox_layer(added_s));

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Ascon p^a/p^b sequencer: FSM, round counter and state register around the round datapath.
// Build option: ASCON_PERM_TWO_ROUNDS_EN cascades two rounds per clock edge.
module ascon_permutation_ctrl
   import ascon_permutation_ctrl_pkg::*;
(
   input logic                     clock_i,
   input logic                     reset_i,
   ascon_permutation_ctrl_if.slave bus
);

   fsm_e                 fsm_q;
   type_state            state_q;
   type_state            round_out_s;
   logic [RND_CNT_W-1:0] cnt_q;
   logic                 ready_q;
   logic                 done_q;

`ifdef ASCON_PERM_TWO_ROUNDS_EN
   localparam logic [RND_CNT_W-1:0] STEP = 4'd2;

   type_state            mid_s;
   logic [RND_CNT_W-1:0] cnt_second_s;

   assign cnt_second_s = cnt_q + 4'd1;

   ascon_permutation_ctrl_round u_round0 (
      .state_i (state_q),
      .round_i (cnt_q),
      .state_o (mid_s)
   );

   ascon_permutation_ctrl_round u_round1 (
      .state_i (mid_s),
      .round_i (cnt_second_s),
      .state_o (round_out_s)
   );
`else
   localparam logic [RND_CNT_W-1:0] STEP = 4'd1;

   ascon_permutation_ctrl_round u_round0 (
      .state_i (state_q),
      .round_i (cnt_q),
      .state_o (round_out_s)
   );
`endif

   // The edge whose round group ends on index 11 is the last one in RUN.
   localparam logic [RND_CNT_W-1:0] LAST_START = LAST_IDX - (STEP - 4'd1);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         cnt_q   <= 4'd0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  state_q <= bus.state_i;
                  cnt_q   <= start_index(bus.rounds_sel_i);
                  ready_q <= 1'b0;
                  fsm_q   <= ST_RUN;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               state_q <= round_out_s;
               if (cnt_q >= LAST_START) begin
                  done_q <= 1'b1;
                  fsm_q  <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + STEP;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               fsm_q   <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               fsm_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.done_o  = done_q;
   assign bus.state_o = state_q;
   assign bus.round_o = cnt_q;

endmodule
